// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Round-robin arbiter that time-shares one pipelined SPU op among NUM_REQ
// requesters. It issues one accepted request per enabled cycle into the op.
// It then tags each issued operation with its requester id, and returns each
// result to its owner as a one-hot m_valid once the op latency has elapsed.
//
// Handshake: a request transfers on a rising clk edge where s_valid[i] and
// s_ready[i] are both high. s_ready is a pure function of the current
// s_valid, the round-robin pointer, cke and reset. It is never high for more
// than one requester at a time. A requester may drop s_valid at any time.
// The result side has no backpressure. m_valid is a one-cycle strobe in
// enabled cycles, and it is held through cke=0 cycles.
module elixirchip_es1_spu_op_arbiter #(
  parameter int    NUM_REQ    = 4,
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false",
  localparam int   ID_BITS    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cke,
  input  data_t              s_data [NUM_REQ],
  input  logic [NUM_REQ-1:0] s_clear,
  input  logic [NUM_REQ-1:0] s_valid,
  output logic [NUM_REQ-1:0] s_ready,
  output logic               op_cke,
  output logic               op_clear,
  output data_t              op_data,
  output logic               op_valid,
  input  data_t              op_result,
  output logic [NUM_REQ-1:0] m_valid,
  output logic [ID_BITS-1:0] m_id,
  output data_t              m_data,
  output logic               busy
);

  // Vendor/simulation selectors are accepted for drop-in compatibility only.
  if (DEBUG == "true" && SIMULATION == "true" && DEVICE == "") begin : g_cfg_unused
  end

  logic [ID_BITS-1:0] ptr;
  logic [ID_BITS-1:0] grant_idx;
  logic               grant_found;
  logic               handshake;
  logic [ID_BITS-1:0] ptr_next;
  logic [ID_BITS-1:0] op_id;
  logic               src_valid;
  logic [ID_BITS-1:0] src_id;
  logic               tags_busy;
  logic [NUM_REQ-1:0] src_one_hot;

  assign op_cke = cke;

  // Round-robin pick: first valid requester at/after ptr, else first valid from 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && s_valid[i] && (ID_BITS'(i) >= ptr)) begin
        grant_found = 1'b1;
        grant_idx   = ID_BITS'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && s_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_BITS'(i);
      end
    end
  end

  // Ready goes to the single granted requester, only in enabled, non-reset cycles.
  always_comb begin
    s_ready = '0;
    if (cke && !reset && grant_found) begin
      s_ready[grant_idx] = 1'b1;
    end
  end

  assign handshake = |(s_valid & s_ready);
  assign ptr_next  = (grant_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_idx + ID_BITS'(1);

  // Issue stage: capture the granted request into the op input registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      op_valid <= 1'b0;
      op_clear <= 1'b0;
      op_data  <= '0;
      op_id    <= '0;
    end else if (cke) begin
      op_valid <= handshake;
      op_clear <= handshake & s_clear[grant_idx];
      op_id    <= grant_idx;
      if (handshake) begin
        op_data <= s_data[grant_idx];
        ptr     <= ptr_next;
      end
    end
  end

  if (LATENCY == 0) begin : g_no_tag
    assign src_valid = op_valid;
    assign src_id    = op_id;
    assign tags_busy = 1'b0;
  end else begin : g_tag
    logic [LATENCY-1:0] tag_valid;
    logic [ID_BITS-1:0] tag_id [LATENCY];

    // Tag pipeline shadows the op's internal stages so ids line up with op_result.
    always_ff @(posedge clk) begin
      if (reset) begin
        tag_valid <= '0;
        for (int i = 0; i < LATENCY; i++) begin
          tag_id[i] <= '0;
        end
      end else if (cke) begin
        tag_valid[0] <= op_valid;
        tag_id[0]    <= op_id;
        for (int i = 1; i < LATENCY; i++) begin
          tag_valid[i] <= tag_valid[i-1];
          tag_id[i]    <= tag_id[i-1];
        end
      end
    end

    assign src_valid = tag_valid[LATENCY-1];
    assign src_id    = tag_id[LATENCY-1];
    assign tags_busy = |tag_valid;
  end

  // Decode the returning tag into the owner's one-hot valid.
  always_comb begin
    src_one_hot         = '0;
    src_one_hot[src_id] = src_valid;
  end

  // Result register: returns op_result with the owner's id.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= '0;
      m_id    <= '0;
      m_data  <= '0;
    end else if (cke) begin
      m_valid <= src_one_hot;
      m_id    <= src_id;
      m_data  <= op_result;
    end
  end

  assign busy = op_valid | tags_busy | (|m_valid);

endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// Bench for elixirchip_es1_spu_op_arbiter. It runs three builds side by side
// (LATENCY 0, 1 and 8) on shared stimulus. Each build drives its own
// behavioural SPU op, which is a pass-through delay that returns all-ones on
// clear. A scoreboard predicts grants from round-robin rules. It also predicts
// each result's return time, which is the handshake edge plus LATENCY+1 further
// enabled edges.
module tb_elixirchip_es1_spu_op_arbiter;
  localparam int N  = 4;
  localparam int NI = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           cke;
  logic [7:0]     s_data [N];
  logic [N-1:0]   s_clear;
  logic [N-1:0]   s_valid;

  logic [N-1:0]   s_ready_w   [NI];
  logic           op_cke_w    [NI];
  logic           op_clear_w  [NI];
  logic [7:0]     op_data_w   [NI];
  logic           op_valid_w  [NI];
  logic [7:0]     op_result_w [NI];
  logic [N-1:0]   m_valid_w   [NI];
  logic [1:0]     m_id_w      [NI];
  logic [7:0]     m_data_w    [NI];
  logic           busy_w      [NI];

  // Scoreboard entry: [31:30] build, [29:10] due enabled-edge, [9:8] id, [7:0] data.
  logic [31:0]    exp_q [$];
  logic [1:0]     m_ptr;
  int             en_cnt;
  logic [N-1:0]   cur_mv   [NI];
  logic [1:0]     cur_id   [NI];
  logic [7:0]     cur_data [NI];
  bit             known    [NI];
  int             n_checks;
  int             n_errors;

  // Clock generation.
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 8);

    elixirchip_es1_spu_op_arbiter #(
      .NUM_REQ  (N),
      .LATENCY  (L),
      .DATA_BITS(8)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .cke      (cke),
      .s_data   (s_data),
      .s_clear  (s_clear),
      .s_valid  (s_valid),
      .s_ready  (s_ready_w[g]),
      .op_cke   (op_cke_w[g]),
      .op_clear (op_clear_w[g]),
      .op_data  (op_data_w[g]),
      .op_valid (op_valid_w[g]),
      .op_result(op_result_w[g]),
      .m_valid  (m_valid_w[g]),
      .m_id     (m_id_w[g]),
      .m_data   (m_data_w[g]),
      .busy     (busy_w[g])
    );

    if (L == 0) begin : g_op0
      assign op_result_w[g] = op_clear_w[g] ? 8'hFF : op_data_w[g];
    end else begin : g_opn
      logic [7:0] pipe [L];
      // Behavioural SPU op: L-stage delay line, clear loads all-ones.
      always @(posedge clk) begin
        if (op_cke_w[g]) begin
          pipe[0] <= op_clear_w[g] ? 8'hFF : op_data_w[g];
          for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign op_result_w[g] = pipe[L-1];
    end
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) s_data[k] = 8'($urandom);
  endtask

  // One clock cycle: drive at negedge, check ready, update model at posedge, check outputs.
  task automatic run_cycle(input logic c, input logic r, input logic [N-1:0] v,
                           input logic [N-1:0] clr);
    logic         found;
    logic [1:0]   g;
    logic [1:0]   idx;
    logic [N-1:0] exp_ready;
    logic [31:0]  e;
    int           hit;
    bit           pending;
    cke = c; reset = r; s_valid = v; s_clear = clr;
    #1;
    found = 1'b0;
    g     = 2'd0;
    if (c && !r) begin
      for (int k = 0; k < N; k++) begin
        idx = m_ptr + 2'(k);
        if (!found && v[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
    end
    exp_ready = '0;
    if (found) exp_ready[g] = 1'b1;
    for (int i = 0; i < NI; i++)
      check($sformatf("s_ready L%0d", lat_of(i)), 32'(s_ready_w[i]), 32'(exp_ready));

    @(posedge clk);
    if (r) begin
      m_ptr = 2'd0;
      exp_q.delete();
      for (int i = 0; i < NI; i++) begin
        cur_mv[i] = '0; cur_id[i] = '0; cur_data[i] = '0; known[i] = 1'b1;
      end
    end else if (c) begin
      en_cnt++;
      if (found) begin
        for (int i = 0; i < NI; i++)
          exp_q.push_back({2'(i), 20'(en_cnt + lat_of(i) + 1), g,
                           (clr[g] ? 8'hFF : s_data[g])});
        m_ptr = g + 2'd1;
      end
    end

    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!r && c) begin
        hit = -1;
        for (int q = 0; q < exp_q.size(); q++)
          if (hit < 0 && exp_q[q][31:30] == 2'(i)) hit = q;
        cur_mv[i] = '0;
        known[i]  = 1'b0;
        if (hit >= 0) begin
          e = exp_q[hit];
          if (e[29:10] == 20'(en_cnt)) begin
            cur_mv[i][e[9:8]] = 1'b1;
            cur_id[i]   = e[9:8];
            cur_data[i] = e[7:0];
            known[i]    = 1'b1;
            exp_q.delete(hit);
          end
        end
      end
      pending = 1'b0;
      for (int q = 0; q < exp_q.size(); q++)
        if (exp_q[q][31:30] == 2'(i)) pending = 1'b1;
      check($sformatf("m_valid L%0d", lat_of(i)), 32'(m_valid_w[i]), 32'(cur_mv[i]));
      check($sformatf("busy L%0d", lat_of(i)), 32'(busy_w[i]),
            32'(pending || (cur_mv[i] != '0)));
      if (known[i]) begin
        check($sformatf("m_id L%0d", lat_of(i)), 32'(m_id_w[i]), 32'(cur_id[i]));
        check($sformatf("m_data L%0d", lat_of(i)), 32'(m_data_w[i]), 32'(cur_data[i]));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b1, 1'b0, '0, '0);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    n_checks = 0; n_errors = 0; en_cnt = 0; m_ptr = 2'd0;
    for (int i = 0; i < NI; i++) begin
      cur_mv[i] = '0; cur_id[i] = '0; cur_data[i] = '0; known[i] = 1'b0;
    end
    cke = 1'b0; reset = 1'b1; s_valid = '0; s_clear = '0;
    for (int k = 0; k < N; k++) s_data[k] = 8'h00;
    @(negedge clk);

    // Reset state.
    repeat (3) run_cycle(1'b1, 1'b1, '0, '0);

    // Single requester 2 with 0x5A.
    s_data[2] = 8'h5A;
    run_cycle(1'b1, 1'b0, 4'b0100, '0);
    idle(12);

    // All requesters continuously valid: rotating grants, one per cycle.
    repeat (12) begin
      rand_data();
      run_cycle(1'b1, 1'b0, 4'b1111, '0);
    end
    idle(12);

    // Clear request from requester 1.
    s_data[1] = 8'h33;
    run_cycle(1'b1, 1'b0, 4'b0010, 4'b0010);
    check("op_valid after clear", 32'(op_valid_w[1]), 32'd1);
    check("op_clear after clear", 32'(op_clear_w[1]), 32'd1);
    idle(12);

    // Reset with three operations in flight, then first grant after reset.
    repeat (3) begin
      rand_data();
      run_cycle(1'b1, 1'b0, 4'b1111, '0);
    end
    run_cycle(1'b1, 1'b1, 4'b1111, '0);
    run_cycle(1'b1, 1'b0, 4'b1111, '0);
    idle(12);

    // Random traffic with ~10% cke low and rare resets.
    repeat (500) begin
      rand_data();
      run_cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 199) == 0),
                4'($urandom), 4'($urandom) & 4'($urandom) & 4'($urandom));
    end
    idle(12);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Run-time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
